// File: rtl/cb_cfg_pkg.sv
// ---------------------------------------------------------------------------
// cb_cfg_pkg
//
// Shared sizing helpers and select-code map for the registered-configuration
// connection block. All widths that depend on the block parameters are
// derived through these functions so the top and the input mux agree on
// the layout of the configuration word.
//
// Contents:
//   DEF_WS / DEF_WD / DEF_WG   default track counts
//   SEL_* constants            select-code bases for the default geometry
//   sel_*_base()               the same bases for an arbitrary geometry
//   calc_selw / calc_ow /
//   calc_cfg_bits              derived widths
//   cfg_status_t               packed status flags
// ---------------------------------------------------------------------------
package cb_cfg_pkg;

    localparam int DEF_WS = 8;
    localparam int DEF_WD = 8;
    localparam int DEF_WG = 3;

    // Code 0 always selects a constant zero; singles start right after it.
    localparam int SEL_ZERO        = 0;
    localparam int SEL_SINGLE_BASE = 1;

    function automatic int sel_double_base(input int ws);
        return SEL_SINGLE_BASE + ws;
    endfunction

    function automatic int sel_global_base(input int ws, input int wd);
        return sel_double_base(ws) + wd;
    endfunction

    function automatic int sel_nbr_base(input int ws, input int wd, input int wg);
        return sel_global_base(ws, wd) + wg;
    endfunction

    localparam int SEL_DOUBLE_BASE = sel_double_base(DEF_WS);
    localparam int SEL_GLOBAL_BASE = sel_global_base(DEF_WS, DEF_WD);
    localparam int SEL_NBR_BASE    = sel_nbr_base(DEF_WS, DEF_WD, DEF_WG);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Enough code bits to name the zero source plus every real source.
    function automatic int calc_selw(input int ws, input int wd, input int wg,
                                     input int clbx, input int nbr_w);
        return $clog2(sel_nbr_base(ws, wd, wg) + clbx * nbr_w);
    endfunction

    // Output enables cover all singles and the lower half of the doubles.
    function automatic int calc_ow(input int ws, input int wd);
        return ws + wd / 2;
    endfunction

    function automatic int calc_cfg_bits(input int in0, input int in1,
                                         input int out0, input int out1,
                                         input int selw, input int ow);
        return (in0 + in1) * selw + (out0 + out1) * ow;
    endfunction

    typedef struct packed {
        logic valid;
        logic err;
        logic conflict;
    } cfg_status_t;

endpackage

// File: rtl/cb_input_mux.sv
// ---------------------------------------------------------------------------
// cb_input_mux
//
// One encoded source multiplexer feeding a single CLB input. The select
// code picks constant zero, a single track, a double track, a global line
// or (when CLBX is set) an output of the neighbouring CLB.
//
// Ports:
//   sel        in  SELW  select code from the active configuration
//   single_in  in  WS    single track values
//   double_in  in  WD    double track values
//   global_in  in  WG    global lines
//   nbr_in     in  NW    neighbour CLB outputs
//   value      out 1     selected source
// ---------------------------------------------------------------------------
module cb_input_mux
    import cb_cfg_pkg::*;
#(
    parameter int WS   = 8,
    parameter int WD   = 8,
    parameter int WG   = 3,
    parameter int NW   = 1,
    parameter int CLBX = 1,
    parameter int SELW = 5
) (
    input  logic [SELW-1:0] sel,
    input  logic [WS-1:0]   single_in,
    input  logic [WD-1:0]   double_in,
    input  logic [WG-1:0]   global_in,
    input  logic [NW-1:0]   nbr_in,
    output logic            value
);

    // The source vector is padded to the full code space, so every code
    // past the last real source lands on a zero bit without a range check.
    localparam int SRCW        = 1 << SELW;
    localparam int DOUBLE_BASE = sel_double_base(WS);
    localparam int GLOBAL_BASE = sel_global_base(WS, WD);
    localparam int NBR_BASE    = sel_nbr_base(WS, WD, WG);

    logic [SRCW-1:0] src;
    logic [SRCW-1:0] nbr_field;

    if (CLBX != 0) begin : g_nbr
        assign nbr_field = SRCW'(nbr_in) << NBR_BASE;
    end else begin : g_no_nbr
        assign nbr_field = '0;
    end

    // Bit SEL_ZERO is never set by any field, giving the constant-0 source.
    assign src = (SRCW'(single_in) << SEL_SINGLE_BASE)
               | (SRCW'(double_in) << DOUBLE_BASE)
               | (SRCW'(global_in) << GLOBAL_BASE)
               | nbr_field;

    assign value = src[sel];

endmodule

// File: rtl/connection_block_cfg.sv
// ---------------------------------------------------------------------------
// connection_block_cfg
//
// Connection block between two CLBs and one routing channel, configured by
// a counted serial chain. Bits shift into a shadow register; a commit with
// exactly CFG_BITS shifted bits copies the shadow into the active register
// that drives all routing. Live routing is never disturbed by shifting.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   single_in / double_in        track values (WS / WD)
//   global0                      global lines (WG)
//   single_out, single_oe        per-single drive data / enable
//   double_out, double_oe        per-double drive data / enable (upper half 0)
//   clb0_output / clb1_output    CLB outputs feeding the tracks
//   clb0_input / clb1_input      muxed CLB inputs
//   clb0_cout, clb1_cout         carry outputs of each CLB
//   clb0_cin, clb1_cin           carry inputs, crossed over combinationally
//   cfg_en, cfg_in, cfg_out      serial shift enable, data in, shadow[0]
//   cfg_commit                   one-cycle commit request
//   cfg_valid, cfg_err,
//   cfg_conflict                 configuration status
// ---------------------------------------------------------------------------
module connection_block_cfg
    import cb_cfg_pkg::*;
#(
    parameter int WS      = DEF_WS,
    parameter int WD      = DEF_WD,
    parameter int WG      = DEF_WG,
    parameter int CLBIN0  = 6,
    parameter int CLBIN1  = 6,
    parameter int CLBOUT0 = 1,
    parameter int CLBOUT1 = 1,
    parameter int CARRY   = 1,
    parameter int CLBX    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WS-1:0]      single_in,
    input  logic [WD-1:0]      double_in,
    input  logic [WG-1:0]      global0,
    output logic [WS-1:0]      single_out,
    output logic [WS-1:0]      single_oe,
    output logic [WD-1:0]      double_out,
    output logic [WD-1:0]      double_oe,
    input  logic [CLBOUT0-1:0] clb0_output,
    input  logic [CLBOUT1-1:0] clb1_output,
    output logic [CLBIN0-1:0]  clb0_input,
    output logic [CLBIN1-1:0]  clb1_input,
    input  logic [CARRY-1:0]   clb0_cout,
    input  logic [CARRY-1:0]   clb1_cout,
    output logic [CARRY-1:0]   clb0_cin,
    output logic [CARRY-1:0]   clb1_cin,
    input  logic               cfg_en,
    input  logic               cfg_in,
    output logic               cfg_out,
    input  logic               cfg_commit,
    output logic               cfg_valid,
    output logic               cfg_err,
    output logic               cfg_conflict
);

    localparam int NW       = max_int(CLBOUT0, CLBOUT1);
    localparam int SELW     = calc_selw(WS, WD, WG, CLBX, NW);
    localparam int OW       = calc_ow(WS, WD);
    localparam int CFG_BITS = calc_cfg_bits(CLBIN0, CLBIN1, CLBOUT0, CLBOUT1, SELW, OW);
    localparam int NOUT     = CLBOUT0 + CLBOUT1;
    localparam int HALF     = WD / 2;
    localparam int CNTW     = $clog2(CFG_BITS + 2);

    // Field bases inside the configuration word, LSB first.
    localparam int CLB0_IN_BASE  = 0;
    localparam int CLB0_OUT_BASE = CLB0_IN_BASE + CLBIN0 * SELW;
    localparam int CLB1_IN_BASE  = CLB0_OUT_BASE + CLBOUT0 * OW;
    localparam int CLB1_OUT_BASE = CLB1_IN_BASE + CLBIN1 * SELW;

    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(CFG_BITS);
    localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(CFG_BITS + 1);

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic [CNTW-1:0]     count;
    cfg_status_t         status;

    // Carry chain crosses straight between the two CLBs.
    assign clb1_cin = clb0_cout;
    assign clb0_cin = clb1_cout;

    assign cfg_out      = shadow[0];
    assign cfg_valid    = status.valid;
    assign cfg_err      = status.err;
    assign cfg_conflict = status.conflict;

    // -----------------------------------------------------------------------
    // Input multiplexers. Each CLB sees the other CLB's outputs as its
    // neighbour sources, zero-extended to the wider of the two.
    // -----------------------------------------------------------------------
    logic [NW-1:0] nbr_for_clb0;
    logic [NW-1:0] nbr_for_clb1;

    always_comb begin
        nbr_for_clb0 = '0;
        nbr_for_clb0[CLBOUT1-1:0] = clb1_output;
        nbr_for_clb1 = '0;
        nbr_for_clb1[CLBOUT0-1:0] = clb0_output;
    end

    for (genvar i = 0; i < CLBIN0; i++) begin : g_clb0_in
        cb_input_mux #(
            .WS(WS), .WD(WD), .WG(WG), .NW(NW), .CLBX(CLBX), .SELW(SELW)
        ) u_mux (
            .sel       (active[CLB0_IN_BASE + i*SELW +: SELW]),
            .single_in (single_in),
            .double_in (double_in),
            .global_in (global0),
            .nbr_in    (nbr_for_clb0),
            .value     (clb0_input[i])
        );
    end

    for (genvar i = 0; i < CLBIN1; i++) begin : g_clb1_in
        cb_input_mux #(
            .WS(WS), .WD(WD), .WG(WG), .NW(NW), .CLBX(CLBX), .SELW(SELW)
        ) u_mux (
            .sel       (active[CLB1_IN_BASE + i*SELW +: SELW]),
            .single_in (single_in),
            .double_in (double_in),
            .global_in (global0),
            .nbr_in    (nbr_for_clb1),
            .value     (clb1_input[i])
        );
    end

    // -----------------------------------------------------------------------
    // Output enables. Outputs of both CLBs are flattened into one list with
    // CLB0 first, for both the active word (drive) and the shadow word
    // (conflict check ahead of commit).
    // -----------------------------------------------------------------------
    logic [OW-1:0]   act_en  [NOUT];
    logic [OW-1:0]   sh_en   [NOUT];
    logic [NOUT-1:0] drive_bits;

    assign drive_bits = {clb1_output, clb0_output};

    for (genvar k = 0; k < CLBOUT0; k++) begin : g_en0
        assign act_en[k] = active[CLB0_OUT_BASE + k*OW +: OW];
        assign sh_en[k]  = shadow[CLB0_OUT_BASE + k*OW +: OW];
    end

    for (genvar k = 0; k < CLBOUT1; k++) begin : g_en1
        assign act_en[CLBOUT0 + k] = active[CLB1_OUT_BASE + k*OW +: OW];
        assign sh_en[CLBOUT0 + k]  = shadow[CLB1_OUT_BASE + k*OW +: OW];
    end

    // Running OR chains: oe/out accumulate the drive; a track is a conflict
    // when an enable hits a track already claimed by an earlier output.
    logic [OW-1:0] oe_acc  [NOUT+1];
    logic [OW-1:0] out_acc [NOUT+1];
    logic [OW-1:0] seen    [NOUT+1];
    logic [OW-1:0] dup     [NOUT+1];

    assign oe_acc[0]  = '0;
    assign out_acc[0] = '0;
    assign seen[0]    = '0;
    assign dup[0]     = '0;

    for (genvar k = 0; k < NOUT; k++) begin : g_chain
        assign oe_acc[k+1]  = oe_acc[k] | act_en[k];
        assign out_acc[k+1] = out_acc[k] | (act_en[k] & {OW{drive_bits[k]}});
        assign seen[k+1]    = seen[k] | sh_en[k];
        assign dup[k+1]     = dup[k] | (seen[k] & sh_en[k]);
    end

    logic shadow_conflict;
    assign shadow_conflict = |dup[NOUT];

    assign single_out = out_acc[NOUT][WS-1:0];
    assign single_oe  = oe_acc[NOUT][WS-1:0];
    assign double_out = {{(WD-HALF){1'b0}}, out_acc[NOUT][OW-1:WS]};
    assign double_oe  = {{(WD-HALF){1'b0}}, oe_acc[NOUT][OW-1:WS]};

    // -----------------------------------------------------------------------
    // Configuration chain. Commit takes priority over a coincident shift and
    // judges the pre-shift count. The counter saturates one past full so any
    // overlong load is still distinguishable from an exact one.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            count  <= '0;
            status <= '0;
        end else if (cfg_commit) begin
            count <= '0;
            if (count == CNT_FULL) begin
                active          <= shadow;
                status.valid    <= 1'b1;
                status.err      <= 1'b0;
                status.conflict <= shadow_conflict;
            end else begin
                status.err <= 1'b1;
            end
        end else if (cfg_en) begin
            shadow <= {cfg_in, shadow[CFG_BITS-1:1]};
            if (count != CNT_SAT) begin
                count <= count + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_connection_block_cfg.sv
// ---------------------------------------------------------------------------
// tb_connection_block_cfg
//
// Drives connection_block_cfg (default geometry) with directed and random
// configuration loads and random track/CLB data, and compares every output
// each cycle against a behavioural model: the shadow register is a queue of
// shifted bits, routing is decoded from select-code ranges, and drive is
// computed per track from the enable masks.
// ---------------------------------------------------------------------------
module tb_connection_block_cfg;
    import cb_cfg_pkg::*;

    localparam int CFGB      = 84;
    localparam int SELW      = 5;
    localparam int OW        = 12;
    localparam int IN0_BASE  = 0;
    localparam int OUT0_BASE = 30;
    localparam int IN1_BASE  = 42;
    localparam int OUT1_BASE = 72;

    logic       clk;
    logic       rst;
    logic [7:0] single_in;
    logic [7:0] double_in;
    logic [2:0] global0;
    logic [7:0] single_out;
    logic [7:0] single_oe;
    logic [7:0] double_out;
    logic [7:0] double_oe;
    logic [0:0] clb0_output;
    logic [0:0] clb1_output;
    logic [5:0] clb0_input;
    logic [5:0] clb1_input;
    logic [0:0] clb0_cout;
    logic [0:0] clb1_cout;
    logic [0:0] clb0_cin;
    logic [0:0] clb1_cin;
    logic       cfg_en;
    logic       cfg_in;
    logic       cfg_out;
    logic       cfg_commit;
    logic       cfg_valid;
    logic       cfg_err;
    logic       cfg_conflict;

    connection_block_cfg dut (
        .clk          (clk),
        .rst          (rst),
        .single_in    (single_in),
        .double_in    (double_in),
        .global0      (global0),
        .single_out   (single_out),
        .single_oe    (single_oe),
        .double_out   (double_out),
        .double_oe    (double_oe),
        .clb0_output  (clb0_output),
        .clb1_output  (clb1_output),
        .clb0_input   (clb0_input),
        .clb1_input   (clb1_input),
        .clb0_cout    (clb0_cout),
        .clb1_cout    (clb1_cout),
        .clb0_cin     (clb0_cin),
        .clb1_cin     (clb1_cin),
        .cfg_en       (cfg_en),
        .cfg_in       (cfg_in),
        .cfg_out      (cfg_out),
        .cfg_commit   (cfg_commit),
        .cfg_valid    (cfg_valid),
        .cfg_err      (cfg_err),
        .cfg_conflict (cfg_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit          shadowQ[$];
    logic [83:0] activeM;
    int          countM;
    bit          validM;
    bit          errM;
    bit          conflictM;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [83:0] shadowVec();
        logic [83:0] v;
        for (int j = 0; j < CFGB; j++) v[j] = shadowQ[j];
        return v;
    endfunction

    function automatic logic [83:0] withSel(input logic [83:0] v, input int base,
                                            input int idx, input int code);
        logic [83:0] r;
        logic [31:0] c;
        r = v;
        c = code;
        r[base + idx*SELW +: SELW] = c[SELW-1:0];
        return r;
    endfunction

    function automatic logic [83:0] withEn(input logic [83:0] v, input int base,
                                           input int mask);
        logic [83:0] r;
        logic [31:0] m;
        r = v;
        m = mask;
        r[base +: OW] = m[OW-1:0];
        return r;
    endfunction

    // Source value for a select code, read from the live bench inputs.
    function automatic int srcVal(input int code, input bit isClb0);
        int s;
        int d;
        int g;
        s = int'(single_in);
        d = int'(double_in);
        g = int'(global0);
        if (code == SEL_ZERO) return 0;
        if (code < SEL_DOUBLE_BASE) return (s >> (code - SEL_SINGLE_BASE)) & 1;
        if (code < SEL_GLOBAL_BASE) return (d >> (code - SEL_DOUBLE_BASE)) & 1;
        if (code < SEL_NBR_BASE)    return (g >> (code - SEL_GLOBAL_BASE)) & 1;
        if (code == SEL_NBR_BASE)   return isClb0 ? int'(clb1_output) : int'(clb0_output);
        return 0;
    endfunction

    function automatic bit hasConflict(input logic [83:0] v);
        int e0;
        int e1;
        e0 = int'(v[OUT0_BASE +: OW]);
        e1 = int'(v[OUT1_BASE +: OW]);
        for (int t = 0; t < OW; t++) begin
            if ((((e0 >> t) & 1) + ((e1 >> t) & 1)) >= 2) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic modelReset();
        shadowQ = {};
        for (int j = 0; j < CFGB; j++) shadowQ.push_back(1'b0);
        activeM   = '0;
        countM    = 0;
        validM    = 1'b0;
        errM      = 1'b0;
        conflictM = 1'b0;
    endtask

    task automatic modelEdge(input bit en, input bit din, input bit commit, input bit rstv);
        if (rstv) begin
            modelReset();
        end else if (commit) begin
            if (countM == CFGB) begin
                activeM   = shadowVec();
                validM    = 1'b1;
                errM      = 1'b0;
                conflictM = hasConflict(activeM);
            end else begin
                errM = 1'b1;
            end
            countM = 0;
        end else if (en) begin
            shadowQ.push_back(din);
            void'(shadowQ.pop_front());
            if (countM < CFGB + 1) countM++;
        end
    endtask

    task automatic checkAll();
        int exp0;
        int exp1;
        int e0;
        int e1;
        int oeAll;
        int outAll;
        exp0 = 0;
        exp1 = 0;
        for (int i = 0; i < 6; i++) begin
            exp0 |= srcVal(int'(activeM[IN0_BASE + i*SELW +: SELW]), 1'b1) << i;
            exp1 |= srcVal(int'(activeM[IN1_BASE + i*SELW +: SELW]), 1'b0) << i;
        end
        e0     = int'(activeM[OUT0_BASE +: OW]);
        e1     = int'(activeM[OUT1_BASE +: OW]);
        oeAll  = e0 | e1;
        outAll = (clb0_output[0] ? e0 : 0) | (clb1_output[0] ? e1 : 0);
        checkOutput("cfg_out",      32'(cfg_out),      32'(shadowQ[0]));
        checkOutput("cfg_valid",    32'(cfg_valid),    32'(validM));
        checkOutput("cfg_err",      32'(cfg_err),      32'(errM));
        checkOutput("cfg_conflict", 32'(cfg_conflict), 32'(conflictM));
        checkOutput("clb0_input",   32'(clb0_input),   exp0);
        checkOutput("clb1_input",   32'(clb1_input),   exp1);
        checkOutput("single_out",   32'(single_out),   outAll & 'hFF);
        checkOutput("single_oe",    32'(single_oe),    oeAll & 'hFF);
        checkOutput("double_out",   32'(double_out),   (outAll >> 8) & 'hF);
        checkOutput("double_oe",    32'(double_oe),    (oeAll >> 8) & 'hF);
        checkOutput("clb0_cin",     32'(clb0_cin),     32'(clb1_cout));
        checkOutput("clb1_cin",     32'(clb1_cin),     32'(clb0_cout));
    endtask

    task automatic applyStimulus(input bit en, input bit din, input bit commit, input bit rstv);
        @(posedge clk);
        #1;
        cfg_en      = en;
        cfg_in      = din;
        cfg_commit  = commit;
        rst         = rstv;
        single_in   = 8'($urandom);
        double_in   = 8'($urandom);
        global0     = 3'($urandom);
        clb0_output = 1'($urandom);
        clb1_output = 1'($urandom);
        clb0_cout   = 1'($urandom);
        clb1_cout   = 1'($urandom);
    endtask

    // One clock: drive, check mid-cycle against the model, then advance the
    // model for the edge that will sample these inputs.
    task automatic runCycle(input bit en, input bit din, input bit commit, input bit rstv);
        applyStimulus(en, din, commit, rstv);
        #3;
        checkAll();
        modelEdge(en, din, commit, rstv);
    endtask

    task automatic loadBits(input logic [83:0] v, input int n, input bit gaps);
        bit b;
        for (int j = 0; j < n; j++) begin
            b = (j < CFGB) ? v[j] : 1'($urandom);
            if (gaps && $urandom_range(0, 3) == 0) runCycle(1'b0, 1'($urandom), 1'b0, 1'b0);
            runCycle(1'b1, b, 1'b0, 1'b0);
        end
    endtask

    task automatic commitAndSettle();
        runCycle(1'b0, 1'b0, 1'b1, 1'b0);
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [83:0] vA;
    logic [83:0] vB;
    logic [83:0] vC;
    logic [95:0] wide;

    initial begin
        rst         = 1'b1;
        cfg_en      = 1'b0;
        cfg_in      = 1'b0;
        cfg_commit  = 1'b0;
        single_in   = '0;
        double_in   = '0;
        global0     = '0;
        clb0_output = '0;
        clb1_output = '0;
        clb0_cout   = '0;
        clb1_cout   = '0;
        repeat (2) @(posedge clk);
        modelReset();

        $display("[TB] reset state");
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_valid", 32'(cfg_valid), 0);
        checkOutput("rst_oe", 32'(single_oe), 0);

        $display("[TB] single[2] routed to clb0_input[0]");
        vA = withSel('0, IN0_BASE, 0, 3);
        loadBits(vA, CFGB, 1'b1);
        commitAndSettle();
        single_in = 8'h04;
        #1;
        checkOutput("A_in0", 32'(clb0_input[0]), 1);
        checkOutput("A_valid", 32'(cfg_valid), 1);
        single_in = 8'hFB;
        #1;
        checkOutput("A_in0_low", 32'(clb0_input[0]), 0);

        $display("[TB] short and long loads");
        wide = {$urandom, $urandom, $urandom};
        vB = wide[83:0];
        loadBits(vB, CFGB - 1, 1'b1);
        commitAndSettle();
        single_in = 8'h04;
        #1;
        checkOutput("B_short_route", 32'(clb0_input[0]), 1);
        checkOutput("B_short_err", 32'(cfg_err), 1);
        loadBits(vB, CFGB + 1, 1'b0);
        commitAndSettle();
        checkOutput("B_long_err", 32'(cfg_err), 1);
        loadBits(vA, CFGB, 1'b0);
        commitAndSettle();
        checkOutput("B_err_clear", 32'(cfg_err), 0);

        $display("[TB] CLB0 output to single[5] and double[1]");
        vC = withEn('0, OUT0_BASE, 'h220);
        loadBits(vC, CFGB, 1'b1);
        commitAndSettle();
        clb0_output = 1'b1;
        #1;
        checkOutput("C_single_out", 32'(single_out), 'h20);
        checkOutput("C_single_oe", 32'(single_oe), 'h20);
        checkOutput("C_double_oe", 32'(double_oe), 'h02);
        checkOutput("C_double_out", 32'(double_out), 'h02);

        $display("[TB] shared single[0]");
        vC = withEn(withEn('0, OUT0_BASE, 1), OUT1_BASE, 1);
        loadBits(vC, CFGB, 1'b0);
        commitAndSettle();
        checkOutput("D_conflict", 32'(cfg_conflict), 1);
        clb0_output = 1'b0;
        clb1_output = 1'b1;
        #1;
        checkOutput("D_or_hi", 32'(single_out[0]), 1);
        clb1_output = 1'b0;
        #1;
        checkOutput("D_or_lo", 32'(single_out[0]), 0);

        $display("[TB] out-of-range and neighbour codes");
        vC = withSel(withSel('0, IN0_BASE, 0, 31), IN0_BASE, 1, 20);
        loadBits(vC, CFGB, 1'b0);
        commitAndSettle();
        single_in   = 8'hFF;
        double_in   = 8'hFF;
        global0     = 3'h7;
        clb1_output = 1'b1;
        #1;
        checkOutput("E_codes", 32'(clb0_input[1:0]), 2);
        checkOutput("E_no_conflict", 32'(cfg_conflict), 0);

        $display("[TB] shift and commit together on the last bit");
        loadBits(vA, CFGB - 1, 1'b0);
        runCycle(1'b1, vA[83], 1'b1, 1'b0);
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("F_err", 32'(cfg_err), 1);

        $display("[TB] reset mid-load and with commit");
        loadBits(vA, 40, 1'b1);
        runCycle(1'b0, 1'b0, 1'b0, 1'b1);
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("G_valid", 32'(cfg_valid), 0);
        checkOutput("G_err", 32'(cfg_err), 0);
        checkOutput("G_cfg_out", 32'(cfg_out), 0);
        checkOutput("G_clb0_input", 32'(clb0_input), 0);
        loadBits(vA, CFGB, 1'b0);
        runCycle(1'b0, 1'b0, 1'b1, 1'b1);
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("G_commit_rst", 32'(cfg_valid), 0);

        $display("[TB] random loads");
        for (int it = 0; it < 40; it++) begin
            int r;
            int n;
            wide = {$urandom, $urandom, $urandom};
            r = $urandom_range(0, 9);
            if (r < 7)       n = CFGB;
            else if (r == 7) n = CFGB - 1;
            else if (r == 8) n = CFGB + 1;
            else             n = $urandom_range(1, 95);
            loadBits(wide[83:0], n, 1'b1);
            r = $urandom_range(0, 9);
            if (r == 0)      runCycle(1'b0, 1'b0, 1'($urandom), 1'b1);
            else if (r < 3)  runCycle(1'b1, 1'($urandom), 1'b1, 1'b0);
            else             runCycle(1'b0, 1'b0, 1'b1, 1'b0);
            repeat (2) runCycle(1'b0, 1'($urandom), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
